// File: rtl/fifo_pkg.sv
// Shared types for the async FIFO read-side blocks: output-buffer occupancy states and depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

    // Number of words the read-side output buffer can hold.
    localparam int OUT_DEPTH = 2;

    // Occupancy of the output buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } r_occ_e;

endpackage

// File: rtl/r_out_buf.sv
// Two-entry head/tail register buffer feeding the read-side output stream.
// Latency: a write lands in the head (or tail) at the end of the write cycle; head is a flop.
// Backpressure: holds up to two words; the issuer must never write while two words are stored.
module r_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            level_o
);

    r_occ_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    // Occupancy state and both data entries; reset drops any stored words.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next occupancy and data movement: a write goes to the head whenever the buffer is empty after the pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            OCC_EMPTY: begin
                if (wr_i) begin
                    state_d = OCC_ONE;
                    head_d  = wdata_i;
                end
            end
            OCC_ONE: begin
                if (wr_i && !pop_i) begin
                    state_d = OCC_TWO;
                    tail_d  = wdata_i;
                end else if (wr_i && pop_i) begin
                    head_d  = wdata_i;
                end else if (pop_i) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop_i) begin
                    state_d = OCC_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    assign head_o  = head_q;
    assign level_o = state_q;

    // The issue logic keeps stored + in-flight words at or below two, so a full buffer never sees a write.
    a_no_wr_when_full: assert property (@(posedge r_clk) disable iff (!r_rst_n)
        !(wr_i && (state_q == OCC_TWO)));

endmodule

// File: rtl/r_fwft_out_stage.sv
// First-word-fall-through read stage: issues memory reads and streams the returned words out valid/ready.
// Latency: r_empty low in cycle N -> r_inc in N -> data in N+1 -> m_valid in N+2; 1 word/cycle sustained.
// Backpressure: with m_ready low, issue stops once buffered + in-flight words reach two; nothing is lost.
module r_fwft_out_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  r_empty,
    output logic                  r_inc,
    input  logic [DATA_WIDTH-1:0] r_mem_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            r_level
);

    logic       inflight_q, inflight_d;
    logic       pop;
    logic [1:0] level;
    logic [2:0] occ_after_pop;

    assign pop = m_valid & m_ready;

    // Words that will be held or still returning once this cycle's pop is taken out.
    assign occ_after_pop = {1'b0, level} + {2'b0, inflight_q} - {2'b0, pop};

    // Issue only when the FIFO has data and the buffer can absorb the word returning next cycle.
    assign r_inc      = ~r_empty & (occ_after_pop < 3'(OUT_DEPTH));
    assign inflight_d = r_inc;

    // The memory answers one cycle after an accepted read; remember that a word is on its way.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    r_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .r_clk   (r_clk),
        .r_rst_n (r_rst_n),
        .wr_i    (inflight_q),
        .wdata_i (r_mem_data),
        .pop_i   (pop),
        .head_o  (m_data),
        .level_o (level)
    );

    assign r_level = level;
    assign m_valid = (level != 2'd0);

endmodule

// File: tb/tb_r_fwft_out_stage.sv
// Bench for the read-side FWFT stage: FIFO/memory environment, stream model and scoreboard.
// Latency: n/a.
// Backpressure: m_ready driven from directed and random patterns.
module tb_r_fwft_out_stage;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_empty = 1'b1;
    logic       r_inc;
    logic [7:0] r_mem_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] r_level;

    r_fwft_out_stage #(.DATA_WIDTH(8)) dut (
        .r_clk      (r_clk),
        .r_rst_n    (r_rst_n),
        .r_empty    (r_empty),
        .r_inc      (r_inc),
        .r_mem_data (r_mem_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .r_level    (r_level)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int failures = 0;

    // FIFO environment: memory contents, write count, read pointer.
    logic [7:0] mem [0:2047];
    int wr_cnt = 0;
    int rd_ptr = 0;

    // Stream model: words issued but not yet delivered, in issue order.
    logic [7:0] q[$];
    int arr = 0;    // words returned by memory and not yet popped
    int pend = 0;   // 1 when a word is returning this cycle
    logic [7:0] dlog[$];
    int empty_viol = 0;

    // Last sampled DUT outputs.
    int s_inc, s_valid, s_data, s_level, s_pop;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_cnt] = v;
        wr_cnt++;
        r_empty = (rd_ptr >= wr_cnt);
    endtask

    task automatic model_reset();
        q.delete();
        dlog.delete();
        arr = 0;
        pend = 0;
        wr_cnt = 0;
        rd_ptr = 0;
        r_empty = 1'b1;
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance environment and model.
    task automatic tick();
        int exp_pop;
        int exp_inc;
        @(negedge r_clk);
        s_inc   = int'(r_inc);
        s_valid = int'(m_valid);
        s_data  = int'(m_data);
        s_level = int'(r_level);
        s_pop   = int'(m_valid && m_ready);
        exp_pop = (arr != 0 && m_ready) ? 1 : 0;
        exp_inc = (!r_empty && (arr + pend - exp_pop < 2)) ? 1 : 0;
        chk("r_level", s_level, arr);
        chk("m_valid", s_valid, (arr != 0) ? 1 : 0);
        chk("r_inc", s_inc, exp_inc);
        if (arr != 0 && q.size() != 0) chk("m_data", s_data, int'(q[0]));
        if (s_inc != 0 && r_empty) empty_viol++;
        if (s_pop != 0) dlog.push_back(m_data);
        @(posedge r_clk);
        #1;
        if (s_pop != 0 && arr > 0) begin
            void'(q.pop_front());
            arr--;
        end
        if (pend != 0) arr++;
        pend = s_inc;
        if (s_inc != 0) begin
            r_mem_data = mem[rd_ptr];
            q.push_back(mem[rd_ptr]);
            rd_ptr++;
        end
        r_empty = (rd_ptr >= wr_cnt);
    endtask

    initial begin
        int cnt, run, maxrun, vrun, vmax, errs, base;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // Reset state while held in reset.
        #3;
        chk("rst_r_inc", int'(r_inc), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_r_level", int'(r_level), 0);
        @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;

        // Idle with r_empty high for 10 cycles.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += s_inc + s_valid + s_level;
        end
        chk("idle_activity", cnt, 0);

        // First word: r_empty falls at cycle 5, data 8'hA5 appears two cycles later.
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        push(8'hA5);
        tick();
        chk("first_inc_c5", s_inc, 1);
        tick();
        chk("first_valid_c6", s_valid, 0);
        tick();
        chk("first_valid_c7", s_valid, 1);
        chk("first_data_c7", s_data, 8'hA5);
        tick();
        chk("first_valid_c8", s_valid, 0);

        // Streaming 16 words with m_ready high.
        dlog.delete();
        for (int i = 0; i < 16; i++) push(8'(i));
        run = 0; maxrun = 0; vrun = 0; vmax = 0; cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            cnt += s_inc;
            run  = (s_inc != 0) ? run + 1 : 0;
            vrun = (s_valid != 0) ? vrun + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (vrun > vmax) vmax = vrun;
        end
        chk("stream_inc_run", maxrun, 16);
        chk("stream_inc_total", cnt, 16);
        chk("stream_valid_run", vmax, 16);
        chk("stream_count", dlog.size(), 16);
        for (int i = 0; i < 16 && i < dlog.size(); i++) chk("stream_word", int'(dlog[i]), i);

        // Backpressure: 20 cycles with m_ready low and data available.
        dlog.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 24; i++) push(8'(100 + i));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt += s_inc;
        end
        chk("bp_inc_pulses", cnt, 2);
        chk("bp_level", s_level, 2);
        chk("bp_valid", s_valid, 1);
        chk("bp_hold_data", s_data, 100);
        m_ready = 1'b1;
        for (int i = 0; i < 100 && dlog.size() < 24; i++) tick();
        tick();
        chk("bp_count", dlog.size(), 24);
        errs = 0;
        for (int i = 0; i < dlog.size(); i++) if (dlog[i] != 8'(100 + i)) errs++;
        chk("bp_order_errs", errs, 0);

        // Drain edge: r_empty rises right after the last read.
        dlog.delete();
        push(8'hC0); push(8'hC1); push(8'hC2);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += s_inc;
        end
        chk("drain_inc_total", cnt, 3);
        chk("drain_count", dlog.size(), 3);
        if (dlog.size() == 3) chk("drain_last", int'(dlog[2]), 8'hC2);
        chk("drain_valid_end", s_valid, 0);

        // Reset pulse mid-stream with words buffered and in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(200 + i));
        tick(); tick();
        r_rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_r_inc", int'(r_inc), 0);
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_m_data", int'(m_data), 0);
        chk("midrst_r_level", int'(r_level), 0);
        tick(); tick();
        r_rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        push(8'hD0); push(8'hD1);
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_count", dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk("post_rst_w0", int'(dlog[0]), 8'hD0);
            chk("post_rst_w1", int'(dlog[1]), 8'hD1);
        end

        // Random m_ready over 1000 words against the scoreboard.
        dlog.delete();
        base = wr_cnt;
        empty_viol = 0;
        for (int i = 0; i < 20000 && dlog.size() < 1000; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (wr_cnt - base < 1000 && $urandom_range(0, 3) != 0) push(8'($urandom));
            tick();
        end
        chk("rand_count", dlog.size(), 1000);
        errs = 0;
        for (int i = 0; i < dlog.size(); i++) if (dlog[i] != mem[base + i]) errs++;
        chk("rand_order_errs", errs, 0);
        chk("rand_inc_while_empty", empty_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
